alu_control_sequencer: RTL and testbench
========================================

Name: alu_control_sequencer

Overview:
- Hardwired control unit that drives the datapath control strobes for fetch and register-to-register ALU instructions.
- Fetch is T0-T2. Execute runs from T3 through T4, T5 or T6, depending on the opcode class.
- Sits beside the datapath: it reads IR and the memory-ready flag and produces every register-in, register-out, ALU and memory strobe.
- It is the driving end of the datapath control interface; the datapath is the receiving end.

Parameters:
- OPW, 5, opcode field width, IR[31:27]
- REGW, 4, register-select field width (Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15])
- NREGS, 16, number of general registers; width of the one-hot Rin/Rout buses

Ports:
- Clock  in  1  system clock; all state changes on the rising edge
- clear  in  1  synchronous, active-low reset
- IR  in  32  instruction register contents from the datapath
- mem_ready  in  1  memory read data valid on Mdatain
- Rin  out  NREGS  one-hot general register load enables
- Rout  out  NREGS  one-hot general register bus drivers
- PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin, Read  out  1 each  datapath strobes
- alu_op  out  OPW  ALU operation select
- Run  out  1  processor running
- instr_done  out  1  one-cycle pulse in the last execute state

Behaviour:
- State register is 4 bits. States: RST, T0, T1, T2, T3, T4, T5, T6, HALT.
- Outputs are Moore: decoded only from the present state and the latched IR fields. There are no combinational paths from mem_ready to the outputs.
- Reset: clear == 0 at a rising edge forces state to RST, regardless of present state, including mid-instruction and mid-wait.
  - In RST, every output is 0, Rin = Rout = 0 and Run = 0.
  - Next state is T0 on the first edge with clear == 1.
- T0: PCout, MARin, IncPC, Zin. Next state T1.
- T1: Zlowout, PCin, Read, MDRin.
  - Stays in T1 while mem_ready == 0; all T1 strobes remain asserted each wait cycle.
  - Goes to T2 on the edge where mem_ready == 1.
- T2: MDRout, IRin. Next state T3.
- IR is sampled into internal opcode/Ra/Rb/Rc registers on the edge leaving T2. Execute states use only these latched copies.
- Opcode classes:
  - Binary ALU, opcodes 00011-01011:
    - T3: Rout[Rb], Yin.
    - T4: Rout[Rc], Zin, alu_op = opcode.
    - T5: Zlowout, Rin[Ra], instr_done. Next state T0.
  - Wide, mul 01110 and div 01111:
    - T3 and T4 as for binary ALU.
    - T5: Zlowout, LOin.
    - T6: Zhighout, HIin, instr_done. Next state T0.
  - Unary, neg 10000 and not 10001:
    - T3: Rout[Rb], Zin, alu_op = opcode.
    - T4: Zlowout, Rin[Ra], instr_done. Next state T0.
  - halt 11011: T3 goes to HALT.
  - nop 11010 and all other opcodes: T3 asserts instr_done only. Next state T0.
- HALT: all outputs 0, Run = 0. Only reset exits HALT.
- alu_op is 0 in every state without Zin, except T0, where alu_op = 00011 (add) for the PC increment.
- Rin and Rout are always one-hot or zero. Writes to Ra == Rb, Ra == Rc or R0 are allowed; no special casing.
- Run = 1 in every state except RST and HALT.

Test Plan:
- Reset, then fetch IR = 0x18918000 (add R1,R2,R3), mem_ready tied 1 -> T0..T5 in 6 cycles after RST. T3 Rout = 0x0004 + Yin; T4 Rout = 0x0008, alu_op = 00011, Zin; T5 Rin = 0x0002, instr_done = 1.
- IR opcode 00111 (shl), Ra = 1, Rb = 2, Rc = 3, with mem_ready low for 3 cycles in T1 -> T1 held 4 cycles with Read = MDRin = PCin = 1 throughout; execution otherwise identical; alu_op = 00111 in T4.
- mul R0,R4,R5 (opcode 01110) -> T5 Zlowout + LOin, T6 Zhighout + HIin, instr_done only in T6; Rin = 0 in T5 and T6.
- not R6,R7 (10001) -> T3 Rout = 0x0080, Zin, alu_op = 10001; T4 Rin = 0x0040; back to T0 in next cycle.
- Unknown opcode 11111 -> instr_done at T3, T0 next. halt 11011 -> HALT, Run = 0, outputs 0 for 10+ cycles; clear low for 1 cycle -> RST then T0.
- clear low during T4 of an add -> next edge RST, all outputs 0, Rin never pulses for that instruction.

Source files
------------

// File: rtl/alu_control_sequencer_if.sv
// Datapath control interface: the sequencer drives the strobes (master) and
// the datapath receives them and returns IR and memory-ready (slave).
interface alu_control_sequencer_if #(
    parameter int OPW   = 5,
    parameter int NREGS = 16
);
    logic [31:0]      IR;
    logic             mem_ready;
    logic [NREGS-1:0] Rin;
    logic [NREGS-1:0] Rout;
    logic             PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
    logic             Yin, Zin, Zlowout, Zhighout, HIin, LOin, Read;
    logic [OPW-1:0]   alu_op;
    logic             Run;
    logic             instr_done;

    modport master (
        input  IR, mem_ready,
        output Rin, Rout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
               Yin, Zin, Zlowout, Zhighout, HIin, LOin, Read, alu_op, Run,
               instr_done
    );
    modport slave (
        output IR, mem_ready,
        input  Rin, Rout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
               Yin, Zin, Zlowout, Zhighout, HIin, LOin, Read, alu_op, Run,
               instr_done
    );
endinterface

// File: rtl/alu_control_sequencer.sv
// Hardwired Moore control unit: fetch in T0-T2, register-to-register ALU
// execute in T3-T6; outputs decode only from state and the latched IR fields.
module alu_control_sequencer #(
    parameter int OPW   = 5,
    parameter int REGW  = 4,
    parameter int NREGS = 16
) (
    input  logic                            Clock,
    input  logic                            clear,
    alu_control_sequencer_if.master         bus
);
    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_e;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_BLO  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_BHI  = OPW'(5'b01011);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01110);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);
    localparam logic [NREGS-1:0] ONE   = NREGS'(1);

    state_e           state_q, state_d;
    logic [OPW-1:0]   opcode_q, opcode_d;
    logic [REGW-1:0]  ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    logic             is_bin, is_wide, is_un, is_halt;
    logic             unused_ir;

    assign unused_ir = ^bus.IR[31-OPW-3*REGW:0];

    always_ff @(posedge Clock) begin
        if (!clear) begin
            state_q  <= S_RST;
            opcode_q <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rc_q     <= rc_d;
        end
    end

    // Instruction fields are captured only on the edge leaving T2.
    always_comb begin
        opcode_d = opcode_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rc_d     = rc_q;
        if (state_q == S_T2) begin
            opcode_d = bus.IR[31 -: OPW];
            ra_d     = bus.IR[31-OPW -: REGW];
            rb_d     = bus.IR[31-OPW-REGW -: REGW];
            rc_d     = bus.IR[31-OPW-2*REGW -: REGW];
        end
    end

    assign is_bin  = (opcode_q >= OP_BLO) && (opcode_q <= OP_BHI);
    assign is_wide = (opcode_q == OP_MUL) || (opcode_q == OP_DIV);
    assign is_un   = (opcode_q == OP_NEG) || (opcode_q == OP_NOT);
    assign is_halt = (opcode_q == OP_HALT);

    always_comb begin
        state_d        = S_RST;
        bus.Rin        = '0;
        bus.Rout       = '0;
        bus.PCout      = 1'b0;
        bus.PCin       = 1'b0;
        bus.IncPC      = 1'b0;
        bus.MARin      = 1'b0;
        bus.MDRin      = 1'b0;
        bus.MDRout     = 1'b0;
        bus.IRin       = 1'b0;
        bus.Yin        = 1'b0;
        bus.Zin        = 1'b0;
        bus.Zlowout    = 1'b0;
        bus.Zhighout   = 1'b0;
        bus.HIin       = 1'b0;
        bus.LOin       = 1'b0;
        bus.Read       = 1'b0;
        bus.alu_op     = '0;
        bus.Run        = 1'b1;
        bus.instr_done = 1'b0;
        case (state_q)
            S_RST: begin
                bus.Run = 1'b0;
                state_d = S_T0;
            end
            S_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zin    = 1'b1;
                bus.alu_op = OP_ADD;
                state_d    = S_T1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                state_d     = bus.mem_ready ? S_T2 : S_T1;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_d    = S_T3;
            end
            S_T3: begin
                state_d = S_T0;
                if (is_bin || is_wide) begin
                    bus.Rout = ONE << rb_q;
                    bus.Yin  = 1'b1;
                    state_d  = S_T4;
                end else if (is_un) begin
                    bus.Rout   = ONE << rb_q;
                    bus.Zin    = 1'b1;
                    bus.alu_op = opcode_q;
                    state_d    = S_T4;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    bus.instr_done = 1'b1;
                end
            end
            S_T4: begin
                state_d = S_T0;
                if (is_un) begin
                    bus.Zlowout    = 1'b1;
                    bus.Rin        = ONE << ra_q;
                    bus.instr_done = 1'b1;
                end else begin
                    bus.Rout   = ONE << rc_q;
                    bus.Zin    = 1'b1;
                    bus.alu_op = opcode_q;
                    state_d    = S_T5;
                end
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                if (is_wide) begin
                    bus.LOin = 1'b1;
                    state_d  = S_T6;
                end else begin
                    bus.Rin        = ONE << ra_q;
                    bus.instr_done = 1'b1;
                    state_d        = S_T0;
                end
            end
            S_T6: begin
                bus.Zhighout   = 1'b1;
                bus.HIin       = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_T0;
            end
            S_HALT: begin
                bus.Run = 1'b0;
                state_d = S_HALT;
            end
            default: begin
                bus.Run = 1'b0;
                state_d = S_RST;
            end
        endcase
    end
endmodule

// File: tb/tb_alu_control_sequencer.sv
// Scoreboard bench: the stimulus pushes the hand-computed outputs expected for
// each cycle; a monitor pops and compares them on the falling edge.
module tb_alu_control_sequencer;
    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic [13:0] strb;
        logic [4:0]  op;
        logic        run;
        logic        done;
    } obs_t;

    localparam logic [13:0] PCOUT = 14'h2000, PCIN = 14'h1000, INCPC = 14'h0800,
                            MARIN = 14'h0400, MDRIN = 14'h0200, MDROUT = 14'h0100,
                            IRIN = 14'h0080, YIN = 14'h0040, ZIN = 14'h0020,
                            ZLOW = 14'h0010, ZHIGH = 14'h0008, HIIN = 14'h0004,
                            LOIN = 14'h0002, READ = 14'h0001;

    logic Clock = 1'b0;
    logic clear = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t  exp_q[$];
    string name_q[$];

    alu_control_sequencer_if #(.OPW(5), .NREGS(16)) dp ();

    alu_control_sequencer #(.OPW(5), .REGW(4), .NREGS(16)) dut (
        .Clock (Clock),
        .clear (clear),
        .bus   (dp)
    );

    always #5 Clock = ~Clock;

    function automatic obs_t mk(logic [15:0] rin, logic [15:0] rout,
                                logic [13:0] strb, logic [4:0] op,
                                logic run, logic done);
        obs_t o;
        o.rin = rin; o.rout = rout; o.strb = strb; o.op = op;
        o.run = run; o.done = done;
        return o;
    endfunction

    function automatic logic [31:0] mkir(logic [4:0] op, logic [3:0] ra,
                                         logic [3:0] rb, logic [3:0] rc);
        return {op, ra, rb, rc, 15'd0};
    endfunction

    // Record the outputs expected for the present state, then advance a cycle.
    task automatic step(obs_t e, string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch(logic [31:0] ir, int nwait);
        dp.IR = ir;
        dp.mem_ready = 1'b1;
        step(mk(0, 0, PCOUT | MARIN | INCPC | ZIN, 5'b00011, 1, 0), "t0");
        dp.mem_ready = 1'b0;
        for (int i = 0; i < nwait; i++)
            step(mk(0, 0, ZLOW | PCIN | READ | MDRIN, 0, 1, 0), "t1_wait");
        dp.mem_ready = 1'b1;
        step(mk(0, 0, ZLOW | PCIN | READ | MDRIN, 0, 1, 0), "t1");
        step(mk(0, 0, MDROUT | IRIN, 0, 1, 0), "t2");
    endtask

    initial begin : monitor
        obs_t  e, a;
        string nm;
        forever begin
            @(negedge Clock);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = mk(dp.Rin, dp.Rout,
                        {dp.PCout, dp.PCin, dp.IncPC, dp.MARin, dp.MDRin,
                         dp.MDRout, dp.IRin, dp.Yin, dp.Zin, dp.Zlowout,
                         dp.Zhighout, dp.HIin, dp.LOin, dp.Read},
                        dp.alu_op, dp.Run, dp.instr_done);
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL %s: got rin=%h rout=%h strb=%h op=%b run=%b done=%b, expected rin=%h rout=%h strb=%h op=%b run=%b done=%b",
                             nm, a.rin, a.rout, a.strb, a.op, a.run, a.done,
                             e.rin, e.rout, e.strb, e.op, e.run, e.done);
                end
            end
        end
    end

    initial begin : stim
        dp.IR = 32'h0;
        dp.mem_ready = 1'b1;
        clear = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        step(mk(0, 0, 0, 0, 0, 0), "rst_held");
        clear = 1'b1;
        step(mk(0, 0, 0, 0, 0, 0), "rst_release");

        // add R1,R2,R3
        fetch(32'h18918000, 0);
        step(mk(0, 16'h0004, YIN, 0, 1, 0), "add_t3");
        step(mk(0, 16'h0008, ZIN, 5'b00011, 1, 0), "add_t4");
        step(mk(16'h0002, 0, ZLOW, 0, 1, 1), "add_t5");

        // shl R1,R2,R3 with three memory wait cycles
        fetch(mkir(5'b00111, 1, 2, 3), 3);
        step(mk(0, 16'h0004, YIN, 0, 1, 0), "shl_t3");
        step(mk(0, 16'h0008, ZIN, 5'b00111, 1, 0), "shl_t4");
        step(mk(16'h0002, 0, ZLOW, 0, 1, 1), "shl_t5");

        // mul R0,R4,R5
        fetch(mkir(5'b01110, 0, 4, 5), 0);
        step(mk(0, 16'h0010, YIN, 0, 1, 0), "mul_t3");
        step(mk(0, 16'h0020, ZIN, 5'b01110, 1, 0), "mul_t4");
        step(mk(0, 0, ZLOW | LOIN, 0, 1, 0), "mul_t5");
        step(mk(0, 0, ZHIGH | HIIN, 0, 1, 1), "mul_t6");

        // not R6,R7
        fetch(mkir(5'b10001, 6, 7, 0), 1);
        step(mk(0, 16'h0080, ZIN, 5'b10001, 1, 0), "not_t3");
        step(mk(16'h0040, 0, ZLOW, 0, 1, 1), "not_t4");

        // unknown opcode
        fetch(mkir(5'b11111, 3, 4, 5), 0);
        step(mk(0, 0, 0, 0, 1, 1), "unk_t3");

        // halt, then leave only through reset
        fetch(mkir(5'b11011, 0, 0, 0), 0);
        step(mk(0, 0, 0, 0, 1, 0), "halt_t3");
        for (int i = 0; i < 11; i++)
            step(mk(0, 0, 0, 0, 0, 0), "halted");
        clear = 1'b0;
        step(mk(0, 0, 0, 0, 0, 0), "halted_clr");
        clear = 1'b1;
        step(mk(0, 0, 0, 0, 0, 0), "halt_rst");

        // add aborted by reset in T4
        fetch(32'h18918000, 0);
        step(mk(0, 16'h0004, YIN, 0, 1, 0), "abort_t3");
        clear = 1'b0;
        step(mk(0, 16'h0008, ZIN, 5'b00011, 1, 0), "abort_t4");
        clear = 1'b1;
        step(mk(0, 0, 0, 0, 0, 0), "abort_rst");
        step(mk(0, 0, PCOUT | MARIN | INCPC | ZIN, 5'b00011, 1, 0), "abort_t0");

        for (int i = 0; i < 50 && exp_q.size() > 0; i++)
            @(posedge Clock);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
